// File: rtl/color_scan_ctrl_if.sv
// rtl/color_scan_ctrl_if.sv - frame buffer read port bundle shared by the VGA reader and the colour scanner
// Signals:
//   vga_req/vga_addr      VGA reader request and address
//   vga_data/vga_valid    data returned to the VGA reader, one cycle after vga_req
//   mem_addr/mem_data     frame buffer read port (data lags address by one cycle)
// Modports:
//   slave   the scan controller (owns mem_addr, vga_data, vga_valid)
//   master  the surrounding system (VGA reader plus frame buffer)
interface color_scan_ctrl_if #(
    parameter int AW = 15
) ();
    logic          vga_req;
    logic [AW-1:0] vga_addr;
    logic [2:0]    vga_data;
    logic          vga_valid;
    logic [AW-1:0] mem_addr;
    logic [2:0]    mem_data;

    modport slave (
        input  vga_req, vga_addr, mem_data,
        output vga_data, vga_valid, mem_addr
    );

    modport master (
        output vga_req, vga_addr, mem_data,
        input  vga_data, vga_valid, mem_addr
    );
endinterface

// File: rtl/color_scan_ctrl.sv
// rtl/color_scan_ctrl.sv - frame buffer scan sequencer and read-port arbiter reporting the dominant RGB111 colour
// Ports:
//   P_clk, rst      clock (rising edge) and asynchronous active-low reset
//   scan_req        level request for one analysis scan
//   frame_done      one-cycle pulse: capture writer finished a frame
//   capture_hold    high from SCAN through DECIDE; capture writer must not write
//   bus             read port bundle (VGA side and frame buffer side)
//   busy            controller is not idle
//   done            one-cycle pulse when color has been updated
//   color           one-hot {R,G,B} dominant colour, 000 on a tie
// Optional feature macro: COLOR_SCAN_AUTO_REARM_EN (rescan on every frame while scan_req stays high)
module color_scan_ctrl #(
    parameter int AW   = 15,
    parameter int NPIX = 25344,
    parameter int CW   = 15
) (
    input  logic                     P_clk,
    input  logic                     rst,
    input  logic                     scan_req,
    input  logic                     frame_done,
    output logic                     capture_hold,
    color_scan_ctrl_if.slave         bus,
    output logic                     busy,
    output logic                     done,
    output logic [2:0]               color
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_FRAME = 3'd1,
        SCAN       = 3'd2,
        DRAIN      = 3'd3,
        DECIDE     = 3'd4
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          rd_v_q, rd_v_d;
    logic [CW-1:0] tally_r_q, tally_r_d;
    logic [CW-1:0] tally_g_q, tally_g_d;
    logic [CW-1:0] tally_b_q, tally_b_d;
    logic [2:0]    color_q, color_d;
    logic          done_q, done_d;
    logic          vga_valid_q, vga_valid_d;

    // VGA has unconditional priority on the shared read port.
    assign bus.mem_addr  = bus.vga_req ? bus.vga_addr : addr_q;
    assign bus.vga_data  = bus.mem_data;
    assign bus.vga_valid = vga_valid_q;

    assign busy         = (state_q != IDLE);
    assign capture_hold = (state_q == SCAN) || (state_q == DRAIN) || (state_q == DECIDE);
    assign done         = done_q;
    assign color        = color_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        color_d     = color_q;
        done_d      = 1'b0;
        vga_valid_d = bus.vga_req;
        // rd_v marks that mem_data this coming cycle belongs to the scan, not to VGA.
        rd_v_d      = (state_q == SCAN) && !bus.vga_req;
        tally_r_d   = tally_r_q;
        tally_g_d   = tally_g_q;
        tally_b_d   = tally_b_q;

        if (rd_v_q) begin
            tally_r_d = tally_r_q + CW'(bus.mem_data[2]);
            tally_g_d = tally_g_q + CW'(bus.mem_data[1]);
            tally_b_d = tally_b_q + CW'(bus.mem_data[0]);
        end

        case (state_q)
            IDLE: begin
                if (scan_req) begin
                    state_d = WAIT_FRAME;
                end
            end
            WAIT_FRAME: begin
                if (frame_done) begin
                    state_d   = SCAN;
                    addr_d    = '0;
                    tally_r_d = '0;
                    tally_g_d = '0;
                    tally_b_d = '0;
                end
            end
            SCAN: begin
                // A cycle lost to VGA simply repeats the same scan address.
                if (!bus.vga_req) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = DRAIN;
                    end else begin
                        addr_d = addr_q + AW'(1);
                    end
                end
            end
            DRAIN: begin
                state_d = DECIDE;
            end
            DECIDE: begin
                done_d = 1'b1;
                if ((tally_r_q > tally_g_q) && (tally_r_q > tally_b_q)) begin
                    color_d = 3'b100;
                end else if ((tally_g_q > tally_r_q) && (tally_g_q > tally_b_q)) begin
                    color_d = 3'b010;
                end else if ((tally_b_q > tally_r_q) && (tally_b_q > tally_g_q)) begin
                    color_d = 3'b001;
                end else begin
                    color_d = 3'b000;
                end
`ifdef COLOR_SCAN_AUTO_REARM_EN
                state_d = scan_req ? WAIT_FRAME : IDLE;
`else
                state_d = IDLE;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge P_clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rd_v_q      <= 1'b0;
            tally_r_q   <= '0;
            tally_g_q   <= '0;
            tally_b_q   <= '0;
            color_q     <= 3'b000;
            done_q      <= 1'b0;
            vga_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rd_v_q      <= rd_v_d;
            tally_r_q   <= tally_r_d;
            tally_g_q   <= tally_g_d;
            tally_b_q   <= tally_b_d;
            color_q     <= color_d;
            done_q      <= done_d;
            vga_valid_q <= vga_valid_d;
        end
    end

endmodule

// File: tb/tb_color_scan_ctrl.sv
// tb/tb_color_scan_ctrl.sv - directed self-checking bench for color_scan_ctrl
module tb_color_scan_ctrl;

    localparam int AW   = 5;
    localparam int NPIX = 16;
    localparam int CW   = 5;

    logic       P_clk;
    logic       rst;
    logic       scan_req;
    logic       frame_done;
    logic       capture_hold;
    logic       busy;
    logic       done;
    logic [2:0] color;

    logic [2:0] fb [0:31];

    int total;
    int bad;

    color_scan_ctrl_if #(.AW(AW)) bus ();

    color_scan_ctrl #(.AW(AW), .NPIX(NPIX), .CW(CW)) dut (
        .P_clk        (P_clk),
        .rst          (rst),
        .scan_req     (scan_req),
        .frame_done   (frame_done),
        .capture_hold (capture_hold),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .color        (color)
    );

    initial P_clk = 1'b0;
    always #5 P_clk = ~P_clk;

    // Frame buffer model: synchronous read, one cycle latency.
    always @(posedge P_clk) bus.mem_data <= fb[bus.mem_addr];

    task automatic load_fb(input logic [2:0] v0, input int n0,
                           input logic [2:0] v1, input int n1,
                           input logic [2:0] v2);
        for (int i = 0; i < 16; i++) begin
            if (i < n0) fb[i] = v0;
            else if (i < n0 + n1) fb[i] = v1;
            else fb[i] = v2;
        end
        for (int i = 16; i < 32; i++) fb[i] = 3'(i % 8);
    endtask

    // Runs one requested scan; VGA contention and stray pulses are injected at given scan cycles.
    task automatic run_scan(input int vs, input int vl, input int pa,
                            output int lat, output int hold, output int vcnt,
                            output int vbad, output int frz_bad, output int extra);
        logic          prev_v;
        logic [AW-1:0] prev_a;
        logic [AW-1:0] saved;
        lat = 0; hold = 0; vcnt = 0; vbad = 0; frz_bad = 0; extra = 0;
        prev_v = 1'b0; prev_a = '0; saved = '0;
        @(negedge P_clk);
        scan_req = 1'b1;
        @(negedge P_clk);
        scan_req = 1'b0;
        frame_done = 1'b1;
        @(negedge P_clk);
        frame_done = 1'b0;
        while (!done && lat < 400) begin
            if (capture_hold) hold++;
            if (vga_valid_chk(prev_v)) vbad++;
            if (prev_v) begin
                vcnt++;
                if (bus.vga_data !== fb[prev_a]) vbad++;
            end
            if (vl > 0 && lat == vs) saved = bus.mem_addr;
            bus.vga_req  = (lat >= vs) && (lat < vs + vl);
            bus.vga_addr = AW'(16 + (lat % 16));
            frame_done   = (lat == pa);
            scan_req     = (lat == pa + 2);
            #1;
            if (vl > 0 && lat == vs + vl && bus.mem_addr !== saved) frz_bad++;
            prev_v = bus.vga_req;
            prev_a = bus.vga_addr;
            @(negedge P_clk);
            lat++;
        end
        bus.vga_req = 1'b0;
        frame_done  = 1'b0;
        scan_req    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge P_clk);
            if (done) extra++;
        end
    endtask

    function automatic logic vga_valid_chk(input logic exp_v);
        return bus.vga_valid !== exp_v;
    endfunction

    task automatic test_reset;
        rst = 1'b0;
        scan_req = 1'b0; frame_done = 1'b0;
        bus.vga_req = 1'b0; bus.vga_addr = '0;
        load_fb(3'b100, 16, 3'b000, 0, 3'b000);
        repeat (2) @(negedge P_clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (capture_hold !== 1'b0) begin bad++; $display("FAIL reset_hold got=%b exp=0", capture_hold); end
        total++; if (bus.vga_valid !== 1'b0) begin bad++; $display("FAIL reset_vga_valid got=%b exp=0", bus.vga_valid); end
        total++; if (color !== 3'b000) begin bad++; $display("FAIL reset_color got=%b exp=000", color); end
        total++; if (bus.mem_addr !== 5'd0) begin bad++; $display("FAIL reset_mem_addr got=%0d exp=0", bus.mem_addr); end
        rst = 1'b1;
        @(negedge P_clk);
        bus.vga_req = 1'b1; bus.vga_addr = 5'd20;
        #1;
        total++; if (bus.mem_addr !== 5'd20) begin bad++; $display("FAIL idle_vga_mux got=%0d exp=20", bus.mem_addr); end
        @(negedge P_clk);
        bus.vga_req = 1'b0;
        total++; if (bus.vga_valid !== 1'b1) begin bad++; $display("FAIL idle_vga_valid got=%b exp=1", bus.vga_valid); end
        total++; if (bus.vga_data !== 3'd4) begin bad++; $display("FAIL idle_vga_data got=%b exp=100", bus.vga_data); end
        @(negedge P_clk);
        total++; if (bus.vga_valid !== 1'b0) begin bad++; $display("FAIL idle_vga_valid_drop got=%b exp=0", bus.vga_valid); end
    endtask

    task automatic test_all_red;
        int lat, hold, vcnt, vbad, frz, extra;
        load_fb(3'b100, 16, 3'b000, 0, 3'b000);
        run_scan(0, 0, -10, lat, hold, vcnt, vbad, frz, extra);
        total++; if (lat !== 18) begin bad++; $display("FAIL red_latency got=%0d exp=18", lat); end
        total++; if (hold !== 18) begin bad++; $display("FAIL red_hold_cycles got=%0d exp=18", hold); end
        total++; if (color !== 3'b100) begin bad++; $display("FAIL red_color got=%b exp=100", color); end
        total++; if (extra !== 0) begin bad++; $display("FAIL red_done_width got=%0d exp=0", extra); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL red_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_green_wins;
        int lat, hold, vcnt, vbad, frz, extra;
        load_fb(3'b010, 6, 3'b001, 5, 3'b000);
        run_scan(0, 0, -10, lat, hold, vcnt, vbad, frz, extra);
        total++; if (lat !== 18) begin bad++; $display("FAIL green_latency got=%0d exp=18", lat); end
        total++; if (color !== 3'b010) begin bad++; $display("FAIL green_color got=%b exp=010", color); end
        load_fb(3'b001, 9, 3'b110, 7, 3'b000);
        run_scan(0, 0, -10, lat, hold, vcnt, vbad, frz, extra);
        total++; if (color !== 3'b001) begin bad++; $display("FAIL blue_color got=%b exp=001", color); end
    endtask

    task automatic test_tie;
        int lat, hold, vcnt, vbad, frz, extra;
        load_fb(3'b100, 5, 3'b010, 5, 3'b000);
        run_scan(0, 0, -10, lat, hold, vcnt, vbad, frz, extra);
        total++; if (color !== 3'b000) begin bad++; $display("FAIL tie_color got=%b exp=000", color); end
        total++; if (lat !== 18) begin bad++; $display("FAIL tie_latency got=%0d exp=18", lat); end
    endtask

    task automatic test_vga_contention;
        int lat, hold, vcnt, vbad, frz, extra;
        // Green leads by one pixel; any skipped or repeated scan read disturbs the result.
        load_fb(3'b100, 5, 3'b010, 6, 3'b000);
        run_scan(6, 4, -10, lat, hold, vcnt, vbad, frz, extra);
        total++; if (lat !== 22) begin bad++; $display("FAIL vga_latency got=%0d exp=22", lat); end
        total++; if (hold !== 22) begin bad++; $display("FAIL vga_hold_cycles got=%0d exp=22", hold); end
        total++; if (vcnt !== 4) begin bad++; $display("FAIL vga_valid_count got=%0d exp=4", vcnt); end
        total++; if (vbad !== 0) begin bad++; $display("FAIL vga_data_errors got=%0d exp=0", vbad); end
        total++; if (frz !== 0) begin bad++; $display("FAIL vga_addr_frozen got=%0d exp=0", frz); end
        total++; if (color !== 3'b010) begin bad++; $display("FAIL vga_color got=%b exp=010", color); end
    endtask

    task automatic test_ignored_inputs;
        int lat, hold, vcnt, vbad, frz, extra;
        load_fb(3'b100, 16, 3'b000, 0, 3'b000);
        @(negedge P_clk);
        frame_done = 1'b1;
        @(negedge P_clk);
        frame_done = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_frame_done_busy got=%b exp=0", busy); end
        run_scan(0, 0, 3, lat, hold, vcnt, vbad, frz, extra);
        total++; if (lat !== 18) begin bad++; $display("FAIL ignore_latency got=%0d exp=18", lat); end
        total++; if (extra !== 0) begin bad++; $display("FAIL ignore_single_done got=%0d exp=0", extra); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignore_busy_after got=%b exp=0", busy); end
        total++; if (color !== 3'b100) begin bad++; $display("FAIL ignore_color got=%b exp=100", color); end
    endtask

    task automatic test_reset_mid_scan;
        int lat, hold, vcnt, vbad, frz, extra;
        int n;
        load_fb(3'b001, 16, 3'b000, 0, 3'b000);
        @(negedge P_clk);
        scan_req = 1'b1;
        @(negedge P_clk);
        scan_req = 1'b0;
        frame_done = 1'b1;
        @(negedge P_clk);
        frame_done = 1'b0;
        n = 0;
        while (bus.mem_addr !== 5'd7 && n < 50) begin
            @(negedge P_clk);
            n++;
        end
        total++; if (n !== 7) begin bad++; $display("FAIL midrst_reach_addr7 got=%0d exp=7", n); end
        rst = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        total++; if (capture_hold !== 1'b0) begin bad++; $display("FAIL midrst_hold got=%b exp=0", capture_hold); end
        total++; if (color !== 3'b000) begin bad++; $display("FAIL midrst_color got=%b exp=000", color); end
        @(negedge P_clk);
        rst = 1'b1;
        run_scan(0, 0, -10, lat, hold, vcnt, vbad, frz, extra);
        total++; if (lat !== 18) begin bad++; $display("FAIL midrst_rescan_latency got=%0d exp=18", lat); end
        total++; if (color !== 3'b001) begin bad++; $display("FAIL midrst_rescan_color got=%b exp=001", color); end
    endtask

`ifdef COLOR_SCAN_AUTO_REARM_EN
    task automatic test_auto_rearm;
        int dones;
        int n;
        load_fb(3'b010, 16, 3'b000, 0, 3'b000);
        dones = 0;
        @(negedge P_clk);
        scan_req = 1'b1;
        @(negedge P_clk);
        for (int f = 0; f < 3; f++) begin
            frame_done = 1'b1;
            @(negedge P_clk);
            frame_done = 1'b0;
            if (f == 2) scan_req = 1'b0;
            n = 0;
            while (!done && n < 100) begin
                @(negedge P_clk);
                n++;
            end
            if (done) dones++;
            if (f < 2) begin
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL rearm_busy_%0d got=%b exp=1", f, busy); end
            end
        end
        total++; if (dones !== 3) begin bad++; $display("FAIL rearm_done_count got=%0d exp=3", dones); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rearm_idle_after got=%b exp=0", busy); end
        total++; if (color !== 3'b010) begin bad++; $display("FAIL rearm_color got=%b exp=010", color); end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_all_red();
        test_green_wins();
        test_tie();
        test_vga_contention();
        test_ignored_inputs();
        test_reset_mid_scan();
`ifdef COLOR_SCAN_AUTO_REARM_EN
        test_auto_rearm();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
